wb_queue: RTL
=============

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 The parameter DATA_WIDTH SHALL default to 32 and set the width of the write-back data.
REQ-002 The parameter ADDRESS_WIDTH SHALL default to 5 and set the width of the register address.
REQ-003 The parameter DEPTH SHALL default to 4, SHALL be a power of two of at least 2, and set the number of queue entries.
REQ-004 Port clk SHALL be an input, 1 bit wide: the single clock, all state updating on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit wide: reset, asynchronous and active-low.
REQ-006 Port in_valid SHALL be an input, 1 bit wide: the producer presents a write-back request.
REQ-007 Port in_ready SHALL be an output, 1 bit wide: the queue accepts a request this cycle.
REQ-008 Port in_dest SHALL be an input, ADDRESS_WIDTH bits wide: the destination register of the request.
REQ-009 Port in_data SHALL be an input, DATA_WIDTH bits wide: the data of the request.
REQ-010 Port wb_hold SHALL be an input, 1 bit wide: the consumer blocks register-file writes this cycle.
REQ-011 Port rg_wrt_en SHALL be an output, 1 bit wide: the write enable to the register file.
REQ-012 Port rg_wrt_dest SHALL be an output, ADDRESS_WIDTH bits wide: the register-file write address.
REQ-013 Port rg_wrt_data SHALL be an output, DATA_WIDTH bits wide: the register-file write data.
REQ-014 Ports fwd_addr1 and fwd_addr2 SHALL be inputs, ADDRESS_WIDTH bits wide each: the forwarding lookup addresses.
REQ-015 Ports fwd_hit1 and fwd_hit2 SHALL be outputs, 1 bit wide each: a pending entry matches the corresponding lookup address.
REQ-016 Ports fwd_data1 and fwd_data2 SHALL be outputs, DATA_WIDTH bits wide each: the data of the youngest matching entry.
REQ-017 Port count SHALL be an output, clog2(DEPTH)+1 bits wide: the number of occupied entries.
REQ-018 Port wr_total SHALL be an output, 16 bits wide: a saturating count of committed writes.

Function
REQ-019 The queue SHALL be a circular FIFO with a head pointer, a tail pointer and an occupancy count in the range 0..DEPTH.
REQ-020 in_ready SHALL equal (count != DEPTH); there SHALL be no pass-through when the queue is full, even if a dequeue occurs in the same cycle.
REQ-021 On a clock edge with in_valid=1, in_ready=1 and in_dest!=0, the queue SHALL write in_dest and in_data at the tail and advance the tail modulo DEPTH.
REQ-022 A request with in_dest==0 SHALL be accepted (handshake completes) but discarded; it SHALL change neither the count nor the tail.
REQ-023 rg_wrt_en SHALL equal (count!=0) AND NOT wb_hold, decoded combinationally.
REQ-024 rg_wrt_dest and rg_wrt_data SHALL show the head entry whenever count!=0 and SHALL be 0 when the queue is empty.
REQ-025 On a clock edge with rg_wrt_en=1, the queue SHALL advance the head modulo DEPTH.
REQ-026 An accepted request SHALL reach rg_wrt_en no earlier than the next cycle, giving a minimum latency of 1 cycle.
REQ-027 A simultaneous enqueue and dequeue SHALL leave the count unchanged; the count SHALL increment by 1 on enqueue only and decrement by 1 on dequeue only.
REQ-028 Entries SHALL reach the register file strictly in acceptance order.
REQ-029 For k=1,2, fwd_hit_k SHALL be 1 when fwd_addr_k!=0 and at least one occupied entry has dest==fwd_addr_k.
REQ-030 For k=1,2, fwd_data_k SHALL hold the data of the youngest such entry on a hit and 0 otherwise.
REQ-031 Forwarding SHALL cover only occupied entries, including the head being written this cycle, and SHALL exclude the request currently on the in_* ports.
REQ-032 wr_total SHALL increment on each edge where rg_wrt_en=1 and SHALL saturate at 16'hFFFF.
REQ-033 in_valid asserted while in_ready=0 SHALL leave all state unchanged.

Reset
REQ-034 rst=0 SHALL immediately clear the head, tail, count, all entry valid state and wr_total, regardless of clk.
REQ-035 During reset the outputs SHALL be: in_ready=1, rg_wrt_en=0, rg_wrt_dest=0, rg_wrt_data=0, fwd_hit1/2=0, fwd_data1/2=0, count=0, wr_total=0.
REQ-036 A reset assertion mid-operation SHALL discard all pending entries without committing any write.
REQ-037 The first enqueue SHALL be possible on the first rising edge after rst returns to 1.

Verification
REQ-038 Scenario basic: enqueue (dest 3, 0x11111111) -> the next cycle shows rg_wrt_en=1, rg_wrt_dest=3, rg_wrt_data=0x11111111, and the following cycle shows count=0 and wr_total=1.
REQ-039 Scenario full/backpressure: wb_hold=1, enqueue dests 1..4 -> count=4 and in_ready=0; a fifth request is held; release wb_hold -> writes 1,2,3,4 in order, then the fifth request is accepted.
REQ-040 Scenario x0 drop: enqueue (dest 0, 0xDEADBEEF) -> in_ready=1, count stays 0, rg_wrt_en never asserts.
REQ-041 Scenario forwarding: wb_hold=1, enqueue (5, 0xA), (7, 0xB), (5, 0xC); fwd_addr1=5, fwd_addr2=6 -> fwd_hit1=1, fwd_data1=0xC, fwd_hit2=0, fwd_data2=0.
REQ-042 Scenario simultaneous events: count=2 with enqueue and dequeue on the same edge -> count stays 2 and the order is preserved across pointer wrap-around (run 10 or more entries through DEPTH=4).
REQ-043 Scenario async reset: drive rst=0 between clock edges while count=3 -> count=0 and rg_wrt_en=0 immediately, no further writes, and wr_total=0.

Source files
------------

// File: rtl/wb_queue.sv
// Write-back queue: in-order circular FIFO that feeds the register-file write port.
// It forwards the youngest pending value for two lookup addresses.

module wb_fwd_port #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 4
) (
  input  logic [AW-1:0]              addr,
  input  logic [DEPTH-1:0]           occ,
  input  logic [DEPTH-1:0][AW-1:0]   dest,
  input  logic [DEPTH-1:0][DW-1:0]   data,
  output logic                       hit,
  output logic [DW-1:0]              hit_data
);
  // Entries arrive sorted oldest-first, so the last match in the loop is the youngest.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occ[i] && (addr != '0) && (dest[i] == addr)) begin
        hit      = 1'b1;
        hit_data = data[i];
      end
    end
  end
endmodule

module wb_queue #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int DEPTH         = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDRESS_WIDTH-1:0]   in_dest,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       wb_hold,
  output logic                       rg_wrt_en,
  output logic [ADDRESS_WIDTH-1:0]   rg_wrt_dest,
  output logic [DATA_WIDTH-1:0]      rg_wrt_data,
  input  logic [ADDRESS_WIDTH-1:0]   fwd_addr1,
  input  logic [ADDRESS_WIDTH-1:0]   fwd_addr2,
  output logic                       fwd_hit1,
  output logic                       fwd_hit2,
  output logic [DATA_WIDTH-1:0]      fwd_data1,
  output logic [DATA_WIDTH-1:0]      fwd_data2,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                wr_total
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NUM_FWD = 2;

  logic [DEPTH-1:0][ADDRESS_WIDTH-1:0] q_dest;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]    q_data;
  logic [PW-1:0]                       head, tail;
  logic                                enq, deq;

  assign in_ready    = (count != CW'(DEPTH));
  assign enq         = in_valid && in_ready && (in_dest != '0);
  assign rg_wrt_en   = (count != '0) && !wb_hold;
  assign deq         = rg_wrt_en;
  assign rg_wrt_dest = (count != '0) ? q_dest[head] : '0;
  assign rg_wrt_data = (count != '0) ? q_data[head] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      wr_total <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (deq && (wr_total != 16'hFFFF)) wr_total <= wr_total + 16'd1;
    end
  end

  // Payload storage needs no reset: occupancy is tracked solely by count.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_dest[tail] <= in_dest;
      q_data[tail] <= in_data;
    end
  end

  // Rotate storage into age order (index 0 = head) for the lookup ports.
  logic [DEPTH-1:0]                    age_occ;
  logic [DEPTH-1:0][ADDRESS_WIDTH-1:0] age_dest;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]    age_data;

  always_comb begin
    age_occ  = '0;
    age_dest = '0;
    age_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age_occ[i]  = (CW'(i) < count);
      age_dest[i] = q_dest[head + PW'(i)];
      age_data[i] = q_data[head + PW'(i)];
    end
  end

  logic [NUM_FWD-1:0][ADDRESS_WIDTH-1:0] fwd_addr;
  logic [NUM_FWD-1:0]                    fwd_hit;
  logic [NUM_FWD-1:0][DATA_WIDTH-1:0]    fwd_data;

  assign fwd_addr = {fwd_addr2, fwd_addr1};

  genvar g;
  generate
    for (g = 0; g < NUM_FWD; g++) begin : g_fwd
      wb_fwd_port #(.DW(DATA_WIDTH), .AW(ADDRESS_WIDTH), .DEPTH(DEPTH)) u_port (
        .addr     (fwd_addr[g]),
        .occ      (age_occ),
        .dest     (age_dest),
        .data     (age_data),
        .hit      (fwd_hit[g]),
        .hit_data (fwd_data[g])
      );
    end
  endgenerate

  assign fwd_hit1  = fwd_hit[0];
  assign fwd_hit2  = fwd_hit[1];
  assign fwd_data1 = fwd_data[0];
  assign fwd_data2 = fwd_data[1];
endmodule
